// File: rtl/lcd_spi_write.sv
// lcd_spi_write
//   4-wire SPI byte writer for the LCD command/pixel path. A 9-bit word
//   {D/C, byte} is loaded when en_write is seen high in IDLE. The byte is
//   shifted out MSB-first in SPI mode 0 (SCLK idles low, data changes on the
//   falling edge, the LCD samples on the rising edge). wr_done pulses for
//   one cycle per byte. A fixed GAP then lets the caller's registered
//   wr_done -> data update settle before en_write is sampled again.
//
// Parameters
//   CLK_DIV     sys_clk cycles per SCLK half-period (1..255)
//   GAP_CYCLES  idle cycles after wr_done before re-sampling (1..15)
//
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   data[8:0]  in   {D/C, payload}, sampled only in LOAD
//   en_write   in   level request, starts a byte when high in IDLE
//   wr_done    out  one-cycle pulse when the byte has been fully shifted
//   busy       out  high whenever the FSM is not in IDLE
//   lcd_sclk   out  SPI clock, idles low
//   lcd_mosi   out  SPI data
//   lcd_cs_n   out  chip select, active low
//   lcd_dc     out  data/command select, holds between bytes
//
// Build option
//   LCD_SPI_WRITE_CS_HOLD_EN  when defined, lcd_cs_n is kept low across
//   back-to-back bytes and only released in IDLE once en_write is low.

module lcd_spi_write #(
  parameter int CLK_DIV    = 1,
  parameter int GAP_CYCLES = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_sclk,
  output logic       lcd_mosi,
  output logic       lcd_cs_n,
  output logic       lcd_dc
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  logic [2:0] state;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [3:0] gap_cnt;
  // Only the bits still to be sent are kept; bit 7 goes straight to
  // lcd_mosi in LOAD, so shift_reg[6] is always the next bit out.
  logic [6:0] shift_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      div_cnt   <= 8'd0;
      bit_cnt   <= 3'd0;
      gap_cnt   <= 4'd0;
      shift_reg <= 7'd0;
      wr_done   <= 1'b0;
      busy      <= 1'b0;
      lcd_sclk  <= 1'b0;
      lcd_mosi  <= 1'b0;
      lcd_cs_n  <= 1'b1;
      lcd_dc    <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef LCD_SPI_WRITE_CS_HOLD_EN
          // The CS frame only closes once the caller stops requesting.
          if (!en_write) begin
            lcd_cs_n <= 1'b1;
          end
`endif
          if (en_write) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end

        ST_LOAD: begin
          shift_reg <= data[6:0];
          lcd_mosi  <= data[7];
          lcd_dc    <= data[8];
          lcd_cs_n  <= 1'b0;
          bit_cnt   <= 3'd0;
          div_cnt   <= 8'd0;
          state     <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= 8'd0;
            lcd_sclk <= ~lcd_sclk;
            // Only the high->low toggle moves data; the rising edge is
            // where the LCD samples, so MOSI must be stable across it.
            if (lcd_sclk) begin
              if (bit_cnt == 3'd7) begin
                state   <= ST_DONE;
                wr_done <= 1'b1;
`ifndef LCD_SPI_WRITE_CS_HOLD_EN
                lcd_cs_n <= 1'b1;
`endif
              end else begin
                bit_cnt   <= bit_cnt + 3'd1;
                lcd_mosi  <= shift_reg[6];
                shift_reg <= {shift_reg[5:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        ST_DONE: begin
          gap_cnt <= 4'd0;
          state   <= ST_GAP;
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_write.sv
// tb_lcd_spi_write
//   Directed bench for lcd_spi_write with CLK_DIV=2, GAP_CYCLES=3.
//   Stimulus pushes the expected {dc, byte} into a queue when a word is
//   issued; an independent monitor rebuilds each byte from MOSI on SCLK
//   rising edges and checks it against the queue on every wr_done.
//   Define LCD_SPI_WRITE_CS_HOLD_EN for both bench and RTL to exercise
//   the shared CS frame.

`timescale 1ns/1ps

module tb_lcd_spi_write;

  localparam int CLK_DIV     = 2;
  localparam int GAP_CYCLES  = 3;
  localparam int DONE_EDGE   = 16 * CLK_DIV + 1;
  localparam int BYTE_PERIOD = 16 * CLK_DIV + GAP_CYCLES + 3;

`ifdef LCD_SPI_WRITE_CS_HOLD_EN
  localparam bit CS_HOLD = 1'b1;
`else
  localparam bit CS_HOLD = 1'b0;
`endif

  logic       sys_clk;
  logic       sys_rst_n;
  logic [8:0] data;
  logic       en_write;
  logic       wr_done;
  logic       busy;
  logic       lcd_sclk;
  logic       lcd_mosi;
  logic       lcd_cs_n;
  logic       lcd_dc;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [8:0] exp_q[$];
  logic [8:0] seq_words[16];

  logic [7:0] mon_shift;
  int         mon_bits;
  logic       mon_sclk_prev;
  logic       mon_cs_bad;

  lcd_spi_write #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data      (data),
    .en_write  (en_write),
    .wr_done   (wr_done),
    .busy      (busy),
    .lcd_sclk  (lcd_sclk),
    .lcd_mosi  (lcd_mosi),
    .lcd_cs_n  (lcd_cs_n),
    .lcd_dc    (lcd_dc)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr_done"},  32'(wr_done),  32'd0);
    checkOutput({tag, "_busy"},     32'(busy),     32'd0);
    checkOutput({tag, "_lcd_sclk"}, 32'(lcd_sclk), 32'd0);
    checkOutput({tag, "_lcd_mosi"}, 32'(lcd_mosi), 32'd0);
    checkOutput({tag, "_lcd_cs_n"}, 32'(lcd_cs_n), 32'd1);
    checkOutput({tag, "_lcd_dc"},   32'(lcd_dc),   32'd0);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput({tag, "_reach_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic waitSclkRises(input int rises_needed);
    int rises;
    int n;
    logic prev;
    rises = 0;
    n = 0;
    prev = lcd_sclk;
    while (rises < rises_needed && n < 200) begin
      @(negedge sys_clk);
      n++;
      if (lcd_sclk && !prev) rises++;
      prev = lcd_sclk;
    end
    checkOutput("sclk_rises_seen", 32'(rises), 32'(rises_needed));
  endtask

  // Caller model: wr_done is registered by the caller, which then updates
  // data one cycle later while en_write stays high for the whole sequence.
  task automatic applyStimulus(input int n_words, output int pulses,
                               output int frames, output int spacing);
    int   idx;
    int   cyc;
    int   last_done;
    logic pend;
    logic cs_prev;
    idx = 0;
    cyc = 0;
    pulses = 0;
    frames = 0;
    spacing = 0;
    last_done = 0;
    pend = 1'b0;
    @(negedge sys_clk);
    cs_prev = lcd_cs_n;
    data = seq_words[0];
    exp_q.push_back(seq_words[0]);
    en_write = 1'b1;
    while (pulses < n_words && cyc < n_words * 60) begin
      @(negedge sys_clk);
      cyc++;
      if (cs_prev && !lcd_cs_n) frames++;
      cs_prev = lcd_cs_n;
      if (pend) begin
        pend = 1'b0;
        idx++;
        if (idx < n_words) begin
          data = seq_words[idx];
          exp_q.push_back(seq_words[idx]);
        end
      end
      if (wr_done) begin
        pulses++;
        if (pulses == 2) spacing = cyc - last_done;
        last_done = cyc;
        pend = 1'b1;
        if (pulses == n_words) en_write = 1'b0;
      end
    end
    en_write = 1'b0;
  endtask

  // Monitor: rebuilds each byte from the SPI pins and scores it on wr_done.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      mon_bits      = 0;
      mon_shift     = 8'd0;
      mon_sclk_prev = 1'b0;
      mon_cs_bad    = 1'b0;
    end else begin
      if (lcd_sclk && !mon_sclk_prev) begin
        mon_shift = {mon_shift[6:0], lcd_mosi};
        mon_bits++;
        if (lcd_cs_n) mon_cs_bad = 1'b1;
      end
      mon_sclk_prev = lcd_sclk;
      if (wr_done) begin
        if (exp_q.size() == 0) begin
          check_cnt++;
          $display("[TB] FAIL spurious_wr_done: got byte 0x%0h, expected none",
                   {lcd_dc, mon_shift});
        end else begin
          checkOutput("byte", {23'd0, lcd_dc, mon_shift}, {23'd0, exp_q.pop_front()});
          checkOutput("bit_count", 32'(mon_bits), 32'd8);
          checkOutput("cs_low_at_rise", 32'(mon_cs_bad), 32'd0);
        end
        mon_bits   = 0;
        mon_cs_bad = 1'b0;
      end
    end
  end

  initial begin
    int n;
    int cnt;
    int first_rise;
    int second_rise;
    int pulses;
    int frames;
    int spacing;
    logic prev;

    sys_rst_n = 1'b0;
    en_write  = 1'b0;
    data      = 9'h000;
    repeat (3) @(negedge sys_clk);
    checkResetOutputs("reset");
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single command byte, en_write held for one cycle.
    $display("[TB] single byte 0x02A");
    data = 9'h02A;
    en_write = 1'b1;
    exp_q.push_back(9'h02A);
    @(negedge sys_clk);
    en_write = 1'b0;
    checkOutput("busy_after_sample", 32'(busy), 32'd1);
    n = 0;
    while (!wr_done && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("wr_done_edge", 32'(n), 32'(DONE_EDGE));
    @(negedge sys_clk);
    n++;
    checkOutput("wr_done_one_cycle", 32'(wr_done), 32'd0);
    while (busy && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("busy_fall_edge", 32'(n), 32'(DONE_EDGE + 4));

    // Data byte: CS width and SCLK period.
    $display("[TB] single byte 0x1F8");
    @(negedge sys_clk);
    data = 9'h1F8;
    en_write = 1'b1;
    exp_q.push_back(9'h1F8);
    @(negedge sys_clk);
    en_write = 1'b0;
    n = 0;
    cnt = 0;
    first_rise = -1;
    second_rise = -1;
    prev = lcd_sclk;
    while (!wr_done && n < 200) begin
      if (!lcd_cs_n) cnt++;
      if (lcd_sclk && !prev) begin
        if (first_rise < 0) first_rise = n;
        else if (second_rise < 0) second_rise = n;
      end
      prev = lcd_sclk;
      @(negedge sys_clk);
      n++;
    end
    checkOutput("cs_low_cycles", 32'(cnt), 32'(16 * CLK_DIV));
    checkOutput("first_sclk_rise", 32'(first_rise), 32'(CLK_DIV + 1));
    checkOutput("sclk_period", 32'(second_rise - first_rise), 32'(2 * CLK_DIV));
    waitIdle("byte_1f8");

    // Caller-driven sequence of 11 words.
    $display("[TB] caller sequence of 11 words");
    seq_words[0]  = 9'h02A; seq_words[1]  = 9'h100; seq_words[2]  = 9'h105;
    seq_words[3]  = 9'h100; seq_words[4]  = 9'h10A; seq_words[5]  = 9'h02B;
    seq_words[6]  = 9'h100; seq_words[7]  = 9'h10C; seq_words[8]  = 9'h100;
    seq_words[9]  = 9'h117; seq_words[10] = 9'h02C;
    applyStimulus(11, pulses, frames, spacing);
    checkOutput("seq11_pulses", 32'(pulses), 32'd11);
    checkOutput("seq11_cs_frames", 32'(frames), CS_HOLD ? 32'd1 : 32'd11);
    checkOutput("seq11_byte_period", 32'(spacing), 32'(BYTE_PERIOD));
    waitIdle("seq11");
    repeat (2) @(negedge sys_clk);
    checkOutput("seq11_cs_released", 32'(lcd_cs_n), 32'd1);
    repeat (40) @(negedge sys_clk);
    checkOutput("seq11_queue_drained", 32'(exp_q.size()), 32'd0);

    // Inputs change mid-byte: the byte finishes and nothing else starts.
    $display("[TB] en_write drop mid-byte 0x155");
    @(negedge sys_clk);
    data = 9'h155;
    en_write = 1'b1;
    exp_q.push_back(9'h155);
    waitSclkRises(3);
    en_write = 1'b0;
    data = 9'h1FF;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (wr_done) cnt++;
    end
    checkOutput("drop_pulses", 32'(cnt), 32'd1);
    checkOutput("drop_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-SHIFT.
    $display("[TB] reset mid-shift");
    data = 9'h0F3;
    en_write = 1'b1;
    @(negedge sys_clk);
    en_write = 1'b0;
    waitSclkRises(2);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkResetOutputs("async_rst");
    repeat (2) @(negedge sys_clk);
    checkResetOutputs("held_rst");
    sys_rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (wr_done) cnt++;
    end
    checkOutput("rst_no_wr_done", 32'(cnt), 32'd0);
    data = 9'h0C3;
    en_write = 1'b1;
    exp_q.push_back(9'h0C3);
    @(negedge sys_clk);
    en_write = 1'b0;
    n = 0;
    while (!wr_done && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("post_rst_wr_done_edge", 32'(n), 32'(DONE_EDGE));
    waitIdle("post_rst");

    // Three back-to-back bytes: CS framing.
    $display("[TB] three back-to-back bytes");
    seq_words[0] = 9'h02A;
    seq_words[1] = 9'h1A5;
    seq_words[2] = 9'h03C;
    applyStimulus(3, pulses, frames, spacing);
    checkOutput("seq3_pulses", 32'(pulses), 32'd3);
    checkOutput("seq3_cs_frames", 32'(frames), CS_HOLD ? 32'd1 : 32'd3);
    waitIdle("seq3");
    repeat (2) @(negedge sys_clk);
    checkOutput("seq3_cs_released", 32'(lcd_cs_n), 32'd1);
    repeat (10) @(negedge sys_clk);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
